serial_add_sub_32: RTL and testbench



---
 rtl/serial_add_sub_32.sv | 136 +++++++++++++
 tb/tb_serial_add_sub_32.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_32.sv
// Bit-serial add/subtract engine: one full-adder cell evaluated per clock, LSB first,
// with a start/busy/done handshake and carry/overflow/zero flags.
module serial_add_sub_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             sum_bit;
    logic             cout_bit;
    logic             last_bit;
    logic             accept;
    logic             c_msb;
    logic [WIDTH-1:0] result_shifted;

    // Full-adder cell fed from the shift register LSBs and the carry flop.
    always_comb begin
        sum_bit        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        cout_bit       = ((a_sh_q[0] ^ b_sh_q[0]) & carry_q) | (a_sh_q[0] & b_sh_q[0]);
        last_bit       = (cnt_q == CntW'(WIDTH - 1));
        c_msb          = carry_q;
        result_shifted = {sum_bit, result_q[WIDTH-1:1]};
        accept         = start && (state_q != StRun);
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StRun: begin
                result_d = result_shifted;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = cout_bit;
                cnt_d    = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d     = StDone;
                    carry_out_d = cout_bit;
                    overflow_d  = c_msb ^ cout_bit;
                    zero_d      = (result_shifted == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accept from IDLE or DONE; the latter gives back-to-back operation.
        if (accept) begin
            state_d     = StRun;
            a_sh_d      = op_a;
            b_sh_d      = sub ? ~op_b : op_b;
            carry_d     = sub;
            cnt_d       = '0;
            result_d    = '0;
            carry_out_d = 1'b0;
            overflow_d  = 1'b0;
            zero_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub_32.sv
// Scoreboard bench for serial_add_sub_32: expected results are queued at issue time
// and compared when done pulses.
module tb_serial_add_sub_32;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zro;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    serial_add_sub_32 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference: full-width sum with sign-based overflow rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        exp_t e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        e.res  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        e.zro  = (full[W-1:0] == '0);
        return e;
    endfunction

    // Drives one accept cycle and records the expected result; returns at the
    // negedge just after the accept edge with start low.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        sb.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        sub   = 1'($urandom);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 32'h1234_5678;
        op_b  = 32'h1111_1111;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        vectors++;
        if ({busy, done, carry_out, overflow, zero} !== 5'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[5] = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h8000_0000};
        logic [W-1:0] tb[5] = '{32'h3, 32'h1, 32'h1, 32'h7, 32'h1};
        logic         ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   lat;
        int   busy_cnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], ts[i]);
            busy_cnt = busy ? 1 : 0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (busy) busy_cnt++;
            end while (!done && lat < 100);
            vectors++;
            if (lat != 32) begin
                miscompares++;
                $display("FAIL arith%0d_latency: got %0d cycles, want 32", i, lat);
            end
            vectors++;
            if (busy_cnt != 32) begin
                miscompares++;
                $display("FAIL arith%0d_busy_cycles: got %0d, want 32", i, busy_cnt);
            end
            e = sb.pop_front();
            vectors++;
            if (result !== e.res || carry_out !== e.cout || overflow !== e.ovf ||
                zero !== e.zro) begin
                miscompares++;
                $display("FAIL arith%0d_result: res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                         i, result, carry_out, overflow, zero, e.res, e.cout, e.ovf, e.zro);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || result !== e.res) begin
                miscompares++;
                $display("FAIL arith%0d_done_pulse: done=%b res=%h, want done=0 res=%h",
                         i, done, result, e.res);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   lat;
        exp_t e;
        issue(32'h0000_1000, 32'h0000_0234, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 10);
            op_a  = 32'hDEAD_BEEF;
            op_b  = 32'h0BAD_F00D;
            sub   = 1'b1;
        end while (!done && lat < 100);
        start = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (lat != 32 || result !== e.res) begin
            miscompares++;
            $display("FAIL ignore_start: lat=%0d res=%h, want lat=32 res=%h", lat, result, e.res);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        issue(32'hCAFE_0000, 32'h0000_BABE, 1'b0);
        void'(sb.pop_back());
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b res=%h, want 0 0 0",
                     busy, done, result);
        end
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d active cycles, want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        issue(32'h1, 32'h1, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        e = sb.pop_front();
        vectors++;
        if (lat != 32 || result !== e.res) begin
            miscompares++;
            $display("FAIL b2b_first: lat=%0d res=%h, want lat=32 res=%h", lat, result, e.res);
        end
        // Issue the second op while done is high.
        start = 1'b1;
        op_a  = 32'h3;
        op_b  = 32'h4;
        sub   = 1'b0;
        sb.push_back(model(32'h3, 32'h4, 1'b0));
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        e = sb.pop_front();
        vectors++;
        if (lat != 32 || result !== e.res) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d res=%h, want lat=32 res=%h", lat, result, e.res);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
